// File: rtl/clock_switch_controller_pkg.sv
// Shared types for the clock switch controller: FSM states and source encoding.
package clock_switch_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam logic SOURCE_0 = 1'b0;
    localparam logic SOURCE_1 = 1'b1;

endpackage

// File: rtl/round_robin_arbiter.sv
// One-hot rotating-priority arbiter; priority moves to the index after the last grant.
module round_robin_arbiter #(
    parameter int N = 2
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_enable,
    input  logic [N-1:0] i_request,
    output logic [N-1:0] o_grant
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_next;
    logic             w_found;

    // Scan from the current priority holder and take the first active request.
    always_comb begin
        o_grant    = '0;
        w_ptr_next = r_ptr;
        w_found    = 1'b0;
        if (i_enable) begin
            for (int i = 0; i < N; i++) begin
                if (!w_found && i_request[(int'(r_ptr) + i) % N]) begin
                    o_grant[(int'(r_ptr) + i) % N] = 1'b1;
                    w_ptr_next = PTR_W'((int'(r_ptr) + i + 1) % N);
                    w_found    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end

endmodule

// File: rtl/clock_switch_controller.sv
// Sequences glitch-free clock source switches: arbitrates requests, settles, holds off.
module clock_switch_controller
    import clock_switch_controller_pkg::*;
#(
    parameter int REQUESTERS     = 2,
    parameter int SETTLE_CYCLES  = 8,
    parameter int HOLDOFF_CYCLES = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [REQUESTERS-1:0] i_request_valid,
    input  logic [REQUESTERS-1:0] i_request_source,
    output logic [REQUESTERS-1:0] o_request_ready,
    input  logic                  i_clock_0_alive,
    input  logic                  i_clock_1_alive,
    output logic                  o_select,
    output logic                  o_switching,
    output logic                  o_request_rejected,
    output logic                  o_fallback_taken
);

    localparam int MAXC = (SETTLE_CYCLES > HOLDOFF_CYCLES) ? SETTLE_CYCLES : HOLDOFF_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] SETTLE_LOAD  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLDOFF_LOAD = CW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

    state_t          r_state, w_state_next;
    logic [CW-1:0]   r_count, w_count_next;
    logic            r_select, w_select_next;
    logic            r_rejected, w_rejected_next;
    logic            r_fallback, w_fallback_next;

    logic                  w_sel_alive;
    logic                  w_alt_alive;
    logic                  w_fallback_start;
    logic                  w_arb_enable;
    logic [REQUESTERS-1:0] w_grant;
    logic                  w_granted;
    logic                  w_target;
    logic                  w_target_alive;

    assign w_sel_alive      = (r_select == SOURCE_0) ? i_clock_0_alive : i_clock_1_alive;
    assign w_alt_alive      = (r_select == SOURCE_0) ? i_clock_1_alive : i_clock_0_alive;
    // Fallback outranks requests; nothing is granted while reset is held.
    assign w_fallback_start = (r_state == ST_IDLE) && !i_reset && !w_sel_alive && w_alt_alive;
    assign w_arb_enable     = (r_state == ST_IDLE) && !i_reset && !w_fallback_start;

    round_robin_arbiter #(.N(REQUESTERS)) u_arbiter (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_enable (w_arb_enable),
        .i_request(i_request_valid),
        .o_grant  (w_grant)
    );

    assign w_granted      = |w_grant;
    assign w_target       = |(w_grant & i_request_source);
    assign w_target_alive = (w_target == SOURCE_1) ? i_clock_1_alive : i_clock_0_alive;

    always_comb begin
        w_state_next    = r_state;
        w_count_next    = r_count;
        w_select_next   = r_select;
        w_rejected_next = 1'b0;
        w_fallback_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_fallback_start) begin
                    w_select_next   = ~r_select;
                    w_state_next    = ST_SETTLE;
                    w_count_next    = SETTLE_LOAD;
                    w_fallback_next = 1'b1;
                end else if (w_granted && (w_target != r_select)) begin
                    if (w_target_alive) begin
                        w_select_next = w_target;
                        w_state_next  = ST_SETTLE;
                        w_count_next  = SETTLE_LOAD;
                    end else begin
                        w_rejected_next = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (r_count == '0) begin
                    if (HOLDOFF_CYCLES == 0) begin
                        w_state_next = ST_IDLE;
                        w_count_next = '0;
                    end else begin
                        w_state_next = ST_HOLDOFF;
                        w_count_next = HOLDOFF_LOAD;
                    end
                end else begin
                    w_count_next = r_count - 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (r_count == '0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_count_next = r_count - 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_count_next = '0;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_select   <= SOURCE_0;
            r_rejected <= 1'b0;
            r_fallback <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_select   <= w_select_next;
            r_rejected <= w_rejected_next;
            r_fallback <= w_fallback_next;
        end
    end

    assign o_request_ready    = w_grant;
    assign o_select           = r_select;
    assign o_switching        = (r_state != ST_IDLE);
    assign o_request_rejected = r_rejected;
    assign o_fallback_taken   = r_fallback;

endmodule

// File: tb/tb_clock_switch_controller.sv
// Randomized bench for clock_switch_controller against a busy-countdown reference model.
module tb_clock_switch_controller;

    localparam int N = 2;
    localparam int S = 8;
    localparam int H = 4;

    logic         clk = 1'b0;
    logic         i_reset;
    logic [N-1:0] i_valid, i_src, o_ready;
    logic         i_a0, i_a1;
    logic         o_sel, o_sw, o_rej, o_fb;

    logic         v2, s2, a2, o_ready2, o_sel2, o_sw2, o_rej2, o_fb2;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: switching is a countdown of S+H cycles from the switch edge.
    logic m_sel;
    int   m_busy;
    int   m_ptr;
    logic m_rej, m_fb;
    logic m2_sel;

    always #5 clk = ~clk;

    clock_switch_controller #(.REQUESTERS(N), .SETTLE_CYCLES(S), .HOLDOFF_CYCLES(H)) dut (
        .i_clock(clk), .i_reset(i_reset),
        .i_request_valid(i_valid), .i_request_source(i_src), .o_request_ready(o_ready),
        .i_clock_0_alive(i_a0), .i_clock_1_alive(i_a1),
        .o_select(o_sel), .o_switching(o_sw),
        .o_request_rejected(o_rej), .o_fallback_taken(o_fb)
    );

    clock_switch_controller #(.REQUESTERS(1), .SETTLE_CYCLES(1), .HOLDOFF_CYCLES(0)) dut_b2b (
        .i_clock(clk), .i_reset(i_reset),
        .i_request_valid(v2), .i_request_source(s2), .o_request_ready(o_ready2),
        .i_clock_0_alive(a2), .i_clock_1_alive(a2),
        .o_select(o_sel2), .o_switching(o_sw2),
        .o_request_rejected(o_rej2), .o_fallback_taken(o_fb2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_reset = 1'b1;
        i_valid = '1;
        #1;
        check("rst_ready", o_ready, '0);
        check("rst_select", o_sel, 1'b0);
        check("rst_switching", o_sw, 1'b0);
        check("rst_rejected", o_rej, 1'b0);
        check("rst_fallback", o_fb, 1'b0);
        m_sel  = 1'b0;
        m_busy = 0;
        m_ptr  = 0;
        m_rej  = 1'b0;
        m_fb   = 1'b0;
        m2_sel = 1'b0;
    endtask

    task automatic step(input logic [N-1:0] v, input logic [N-1:0] s, input logic a0, input logic a1);
        logic [1:0]   alive;
        logic [N-1:0] exp_ready;
        logic         fb, tgt;
        int           g, idx;
        @(negedge clk);
        i_reset = 1'b0;
        i_valid = v;
        i_src   = s;
        i_a0    = a0;
        i_a1    = a1;
        #1;
        alive     = {a1, a0};
        fb        = (m_busy == 0) && !alive[m_sel] && alive[!m_sel];
        exp_ready = '0;
        g         = -1;
        if (m_busy == 0 && !fb) begin
            for (int i = 0; i < N; i++) begin
                idx = (m_ptr + i) % N;
                if (g < 0 && v[idx]) begin
                    g = idx;
                    exp_ready[idx] = 1'b1;
                end
            end
        end
        check("ready", o_ready, exp_ready);
        check("select", o_sel, m_sel);
        check("switching", o_sw, m_busy > 0);
        check("rejected", o_rej, m_rej);
        check("fallback", o_fb, m_fb);
        m_rej = 1'b0;
        m_fb  = 1'b0;
        if (m_busy > 0) begin
            m_busy--;
        end else if (fb) begin
            m_sel  = !m_sel;
            m_busy = S + H;
            m_fb   = 1'b1;
            $display("t=%0t fallback to source %0d", $time, m_sel);
        end else if (g >= 0) begin
            m_ptr = (g + 1) % N;
            tgt   = s[g];
            if (tgt != m_sel) begin
                if (alive[tgt]) begin
                    m_sel  = tgt;
                    m_busy = S + H;
                end else begin
                    m_rej = 1'b1;
                end
            end
            $display("t=%0t grant req%0d target %0d select %0d", $time, g, tgt, m_sel);
        end
    endtask

    initial begin
        logic a0r, a1r;
        i_reset = 1'b0; i_valid = '0; i_src = '0; i_a0 = 1'b1; i_a1 = 1'b1;
        v2 = 1'b0; s2 = 1'b0; a2 = 1'b1;

        // Single switch to source 1, then let it settle and hold off.
        do_reset();
        step(2'b01, 2'b01, 1'b1, 1'b1);
        for (int i = 0; i < 14; i++) step(2'b00, 2'b00, 1'b1, 1'b1);

        // Two requesters competing with opposite targets.
        for (int i = 0; i < 60; i++) step(2'b11, 2'b01, 1'b1, 1'b1);

        // Request towards a dead source.
        do_reset();
        step(2'b01, 2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 1'b1, 1'b0);

        // Selected source dies while a request is pending.
        do_reset();
        for (int i = 0; i < 20; i++) step(2'b10, 2'b10, 1'b0, 1'b1);

        // Both sources dead.
        for (int i = 0; i < 6; i++) step(2'b11, 2'b10, 1'b0, 1'b0);

        // Reset three cycles into SETTLE, then an immediate grant after release.
        do_reset();
        step(2'b01, 2'b01, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 1'b1, 1'b1);
        do_reset();
        step(2'b10, 2'b10, 1'b1, 1'b1);
        for (int i = 0; i < 14; i++) step(2'b00, 2'b00, 1'b1, 1'b1);

        // Random traffic with occasional liveness flips and resets.
        a0r = 1'b1; a1r = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) a0r = !a0r;
            if ($urandom_range(0, 39) == 0) a1r = !a1r;
            if ($urandom_range(0, 299) == 0) do_reset();
            step(N'($urandom), N'($urandom), a0r, a1r);
        end

        // Back-to-back switches with one settle cycle and no holdoff.
        do_reset();
        i_valid = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            i_reset = 1'b0;
            v2 = 1'b1;
            s2 = !m2_sel;
            #1;
            check("b2b_ready", o_ready2, (c % 2) == 0);
            check("b2b_select", o_sel2, m2_sel);
            if (c % 2 == 0) m2_sel = !m2_sel;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
